// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state encoding and the matrix position-to-code map
// for the 4x4 keypad scanner.
package keypad_pkg;

    typedef logic [4:0] key_code_t;

    localparam key_code_t KEY_0     = 5'd0;
    localparam key_code_t KEY_1     = 5'd1;
    localparam key_code_t KEY_2     = 5'd2;
    localparam key_code_t KEY_3     = 5'd3;
    localparam key_code_t KEY_4     = 5'd4;
    localparam key_code_t KEY_5     = 5'd5;
    localparam key_code_t KEY_6     = 5'd6;
    localparam key_code_t KEY_7     = 5'd7;
    localparam key_code_t KEY_8     = 5'd8;
    localparam key_code_t KEY_9     = 5'd9;
    localparam key_code_t KEY_A     = 5'd10;
    localparam key_code_t KEY_B     = 5'd11;
    localparam key_code_t KEY_C     = 5'd12;
    localparam key_code_t KEY_D     = 5'd13;
    localparam key_code_t KEY_STAR  = 5'd14;
    localparam key_code_t KEY_HASH  = 5'd15;
    localparam key_code_t KEY_NONE  = 5'd16;
    localparam key_code_t KEY_MULTI = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        PRESSED,
        REL
    } db_state_t;

    function automatic key_code_t key_map(input logic [1:0] r, input logic [1:0] c);
        key_code_t k;
        unique case ({r, c})
            4'h0: k = KEY_1;
            4'h1: k = KEY_2;
            4'h2: k = KEY_3;
            4'h3: k = KEY_A;
            4'h4: k = KEY_4;
            4'h5: k = KEY_5;
            4'h6: k = KEY_6;
            4'h7: k = KEY_B;
            4'h8: k = KEY_7;
            4'h9: k = KEY_8;
            4'hA: k = KEY_9;
            4'hB: k = KEY_C;
            4'hC: k = KEY_STAR;
            4'hD: k = KEY_0;
            4'hE: k = KEY_HASH;
            default: k = KEY_D;
        endcase
        return k;
    endfunction

    function automatic logic key_is_single(input key_code_t k);
        return k < KEY_NONE;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded key outputs; master is the scanner,
// slave is the keypad/consumer side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [3:0] row;
    logic [3:0] col;
    key_code_t  key;
    logic       keypad_pressed;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key,
        output keypad_pressed,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key,
        input  keypad_pressed,
        input  key_held
    );

endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce: turns per-frame key values into an accepted key code,
// a one-clock press strobe and a held flag.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  key_code_t frame_val,
    input  logic      frame_close,
    output key_code_t key,
    output logic      keypad_pressed,
    output logic      key_held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    db_state_t  state;
    key_code_t  cand;
    logic [CNT_W-1:0] cnt;
    logic       last_frame;

    // True when the frame now closing completes the required run length.
    assign last_frame = (32'(cnt) + 32'd1) >= DEBOUNCE_FRAMES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cand           <= KEY_NONE;
            cnt            <= '0;
            key            <= KEY_NONE;
            keypad_pressed <= 1'b0;
            key_held       <= 1'b0;
        end else begin
            keypad_pressed <= 1'b0;
            if (frame_close) begin
                unique case (state)
                    IDLE: begin
                        if (key_is_single(frame_val)) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state          <= PRESSED;
                                key            <= frame_val;
                                key_held       <= 1'b1;
                                keypad_pressed <= 1'b1;
                            end else begin
                                state <= CAND;
                                cand  <= frame_val;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    CAND: begin
                        if (frame_val == cand) begin
                            if (last_frame) begin
                                state          <= PRESSED;
                                key            <= cand;
                                key_held       <= 1'b1;
                                keypad_pressed <= 1'b1;
                                cnt            <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else if (key_is_single(frame_val)) begin
                            cand <= frame_val;
                            cnt  <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (frame_val != key) begin
                            // A single mismatching frame already satisfies a run length of one.
                            if (DEBOUNCE_FRAMES == 1) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                state <= REL;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    REL: begin
                        if (frame_val == key) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (last_frame) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchroniser, per-frame decode and
// debounce, all on the system clock.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 27_000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);

    localparam int unsigned CW = $clog2(SCAN_DIV);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    cidx;

    logic [1:0]    acc_n;
    key_code_t     acc_code;
    logic [2:0]    col_n;
    key_code_t     col_code;
    logic [2:0]    sum_n;
    key_code_t     sum_code;
    key_code_t     frame_now;

    key_code_t     frame_val;
    logic          frame_close;

    assign tick   = (tick_cnt == CW'(SCAN_DIV - 1));
    assign kp.col = ~(4'b0001 << cidx);

    // Low-bit count saturates at 2: only "none / exactly one / several" matters.
    always_comb begin
        col_n    = '0;
        col_code = KEY_NONE;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                if (col_n < 3'd2) col_n = col_n + 3'd1;
                if (col_code == KEY_NONE) col_code = key_map(2'(r), cidx);
            end
        end
        sum_n = {1'b0, acc_n} + col_n;
        if (sum_n > 3'd2) sum_n = 3'd2;
        sum_code = (acc_n != '0) ? acc_code : col_code;
        unique case (sum_n)
            3'd0:    frame_now = KEY_NONE;
            3'd1:    frame_now = sum_code;
            default: frame_now = KEY_MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta    <= '1;
            row_sync    <= '1;
            tick_cnt    <= '0;
            cidx        <= '0;
            acc_n       <= '0;
            acc_code    <= KEY_NONE;
            frame_val   <= KEY_NONE;
            frame_close <= 1'b0;
        end else begin
            row_meta    <= kp.row;
            row_sync    <= row_meta;
            frame_close <= 1'b0;
            if (tick) begin
                tick_cnt <= '0;
                cidx     <= cidx + 2'd1;
                if (cidx == 2'd3) begin
                    frame_val   <= frame_now;
                    frame_close <= 1'b1;
                    acc_n       <= '0;
                    acc_code    <= KEY_NONE;
                end else begin
                    acc_n    <= sum_n[1:0];
                    acc_code <= sum_code;
                end
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_val      (frame_val),
        .frame_close    (frame_close),
        .key            (kp.key),
        .keypad_pressed (kp.keypad_pressed),
        .key_held       (kp.key_held)
    );

endmodule
